// File: rtl/player_ctrl_if.sv
// Player controller bus: frame strobe, joystick and hit inputs plus the
// ship position/status outputs consumed by the sprite renderer and game logic.
//   master : game/frame side (drives Tick, Joystick_data, Hit)
//   slave  : player_ctrl (drives Player_Row/Col, Lives, Visible, Exploding, Game_Over)
interface player_ctrl_if #(
  parameter int unsigned JOY_W = 4,
  parameter int unsigned ROW_W = 9,
  parameter int unsigned COL_W = 10
);
  logic             Tick;
  logic [JOY_W-1:0] Joystick_data;
  logic             Hit;
  logic [ROW_W-1:0] Player_Row;
  logic [COL_W-1:0] Player_Col;
  logic [2:0]       Lives;
  logic             Visible;
  logic             Exploding;
  logic             Game_Over;

  modport master (
    output Tick, Joystick_data, Hit,
    input  Player_Row, Player_Col, Lives, Visible, Exploding, Game_Over
  );

  modport slave (
    input  Tick, Joystick_data, Hit,
    output Player_Row, Player_Col, Lives, Visible, Exploding, Game_Over
  );
endinterface

// File: rtl/player_ctrl.sv
// Player-ship controller: per-Tick horizontal motion with clamped bounds and
// hold-to-accelerate, plus the ALIVE/EXPLODE/RESPAWN/OVER life cycle and lives.
// Ports:
//   Clk    : system clock
//   Reset  : asynchronous, active-high reset
//   pl_if  : player_ctrl_if.slave (Tick, Joystick_data, Hit in;
//            Player_Row, Player_Col, Lives, Visible, Exploding, Game_Over out)
module player_ctrl #(
  parameter int unsigned JOY_W         = 4,
  parameter int unsigned JOY_LO        = 4,
  parameter int unsigned JOY_HI        = 6,
  parameter int unsigned ROW_W         = 9,
  parameter int unsigned COL_W         = 10,
  parameter int unsigned ROW_START     = 400,
  parameter int unsigned COL_START     = 310,
  parameter int unsigned COL_MIN       = 5,
  parameter int unsigned COL_MAX       = 600,
  parameter int unsigned STEP          = 5,
  parameter int unsigned STEP_FAST     = 10,
  parameter int unsigned HOLD_TICKS    = 8,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned EXPLODE_TICKS = 30,
  parameter int unsigned RESPAWN_TICKS = 60
) (
  input logic          Clk,
  input logic          Reset,
  player_ctrl_if.slave pl_if
);

  localparam int unsigned CW1     = COL_W + 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned TMR_MAX = (EXPLODE_TICKS > RESPAWN_TICKS) ? EXPLODE_TICKS : RESPAWN_TICKS;
  // At least 3 bits so the blink phase bit always exists.
  localparam int unsigned TMR_W   = ($clog2(TMR_MAX) < 3) ? 3 : $clog2(TMR_MAX);

  typedef enum logic [1:0] {ST_ALIVE, ST_EXPLODE, ST_RESPAWN, ST_OVER} state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_e;

  state_e            state_q, state_d;
  dir_e              last_dir_q, last_dir_d;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        lives_q, lives_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              vis_q, vis_d;
  logic              expl_q, expl_d;
  logic              over_q, over_d;

  dir_e              dir_c;
  logic              move_en_c;
  logic [CW1-1:0]    step_c;
  logic [CW1-1:0]    col_ext_c;
  logic [CW1-1:0]    right_c;
  logic [CW1-1:0]    left_room_c;

  // Next-state, motion and registered-output decode.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    col_d      = col_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    move_en_c  = 1'b0;

    if (pl_if.Joystick_data > JOY_W'(JOY_HI))      dir_c = DIR_RIGHT;
    else if (pl_if.Joystick_data < JOY_W'(JOY_LO)) dir_c = DIR_LEFT;
    else                                           dir_c = DIR_NONE;

    step_c      = (hold_q >= HOLD_W'(HOLD_TICKS)) ? CW1'(STEP_FAST) : CW1'(STEP);
    col_ext_c   = {1'b0, col_q};
    right_c     = col_ext_c + step_c;
    // Distance to the left wall; col never sits below COL_MIN so this cannot wrap.
    left_room_c = col_ext_c - CW1'(COL_MIN);

    case (state_q)
      ST_ALIVE: begin
        // A hit beats a simultaneous Tick: no motion on that cycle.
        if (pl_if.Hit) begin
          state_d    = ST_EXPLODE;
          lives_d    = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          timer_d    = '0;
          hold_d     = '0;
          last_dir_d = DIR_NONE;
        end else if (pl_if.Tick) begin
          move_en_c = 1'b1;
        end
      end
      ST_EXPLODE: begin
        if (pl_if.Tick) begin
          if (timer_q == TMR_W'(EXPLODE_TICKS - 1)) begin
            timer_d = '0;
            if (lives_q == 3'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_RESPAWN;
              col_d   = COL_W'(COL_START);
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_RESPAWN: begin
        if (pl_if.Tick) begin
          move_en_c = 1'b1;
          if (timer_q == TMR_W'(RESPAWN_TICKS - 1)) begin
            state_d = ST_ALIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      default: ;  // ST_OVER: frozen until Reset
    endcase

    if (move_en_c) begin
      if (dir_c == DIR_RIGHT) begin
        col_d = (right_c > CW1'(COL_MAX)) ? COL_W'(COL_MAX) : right_c[COL_W-1:0];
      end else if (dir_c == DIR_LEFT) begin
        col_d = (left_room_c <= step_c) ? COL_W'(COL_MIN) : COL_W'(col_ext_c - step_c);
      end

      if (dir_c == DIR_NONE)         hold_d = '0;
      else if (dir_c == last_dir_q)  hold_d = (hold_q >= HOLD_W'(HOLD_TICKS)) ? hold_q : hold_q + HOLD_W'(1);
      else                           hold_d = HOLD_W'(1);
      last_dir_d = dir_c;
    end

    // Status outputs track the state being entered so they line up with it.
    vis_d  = (state_d == ST_ALIVE) || ((state_d == ST_RESPAWN) && timer_d[2]);
    expl_d = (state_d == ST_EXPLODE);
    over_d = (state_d == ST_OVER);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_ALIVE;
      last_dir_q <= DIR_NONE;
      row_q      <= ROW_W'(ROW_START);
      col_q      <= COL_W'(COL_START);
      lives_q    <= 3'(LIVES);
      timer_q    <= '0;
      hold_q     <= '0;
      vis_q      <= 1'b1;
      expl_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      row_q      <= ROW_W'(ROW_START);
      col_q      <= col_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      vis_q      <= vis_d;
      expl_q     <= expl_d;
      over_q     <= over_d;
    end
  end

  assign pl_if.Player_Row = row_q;
  assign pl_if.Player_Col = col_q;
  assign pl_if.Lives      = lives_q;
  assign pl_if.Visible    = vis_q;
  assign pl_if.Exploding  = expl_q;
  assign pl_if.Game_Over  = over_q;

endmodule
